// File: rtl/cu_pkg.sv
// ============================================================================
// Module      : cu_pkg
// Description : Opcode constants, sequencer states, instruction classes and
//               the control-strobe bundle shared by the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // State encoding equals the micro-step index so it can be exported as-is.
  typedef enum logic [3:0] {
    S_FETCH0 = 4'd0,
    S_FETCH1 = 4'd1,
    S_FETCH2 = 4'd2,
    S_FETCH3 = 4'd3,
    S_T4     = 4'd4,
    S_T5     = 4'd5,
    S_T6     = 4'd6,
    S_T7     = 4'd7,
    S_T8     = 4'd8,
    S_T9     = 4'd9,
    S_HALT   = 4'd10
  } state_e;

  typedef enum logic [3:0] {
    CL_ALU, CL_IMM, CL_UNARY, CL_MULDIV, CL_LD, CL_LDI, CL_ST, CL_BR,
    CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
  } iclass_e;

  typedef struct packed {
    logic       gra, grb, grc, rin, rout, baout, ryin;
    logic       marin, mdrin, irin, pcin, hiin, loin, zhighin, zlowin, outport_write;
    logic       pcout, mdrout, hiout, loout, zhighout, zlowout, cout, inport_read;
    logic       pc_increment, read, memory_read, memory_write;
    logic [4:0] alu;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/cu_decode.sv
// ============================================================================
// Module      : cu_decode
// Description : Combinational opcode decode into instruction class and the
//               index of the final execute micro-step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cu_decode
  import cu_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_e    iclass,
  output logic [3:0] last_step
);

  always_comb begin
    iclass    = CL_NOP;
    last_step = 4'd3;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
        iclass = CL_ALU;    last_step = 4'd6;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        iclass = CL_IMM;    last_step = 4'd6;
      end
      OP_NEG, OP_NOT: begin
        iclass = CL_UNARY;  last_step = 4'd5;
      end
      OP_MUL, OP_DIV: begin
        iclass = CL_MULDIV; last_step = 4'd7;
      end
      OP_LD:   begin iclass = CL_LD;   last_step = 4'd9; end
      OP_LDI:  begin iclass = CL_LDI;  last_step = 4'd6; end
      OP_ST:   begin iclass = CL_ST;   last_step = 4'd8; end
      OP_BR:   begin iclass = CL_BR;   last_step = 4'd7; end
      OP_JR:   begin iclass = CL_JR;   last_step = 4'd4; end
      OP_JAL:  begin iclass = CL_JAL;  last_step = 4'd5; end
      OP_IN:   begin iclass = CL_IN;   last_step = 4'd4; end
      OP_OUT:  begin iclass = CL_OUT;  last_step = 4'd4; end
      OP_MFHI: begin iclass = CL_MFHI; last_step = 4'd4; end
      OP_MFLO: begin iclass = CL_MFLO; last_step = 4'd4; end
      OP_HALT: begin iclass = CL_HALT; last_step = 4'd3; end
      default: begin iclass = CL_NOP;  last_step = 4'd3; end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module      : control_unit
// Description : Hardwired Moore sequencer for the Mini SRC datapath. Optional
//               single-step gating of FETCH0 is enabled by CU_SINGLE_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit
  import cu_pkg::*;
#(
  parameter logic [4:0] ADD_OP = 5'b00011
) (
  input  logic        clk,
  input  logic        clr,
`ifdef CU_SINGLE_STEP_EN
  input  logic        step_req,
`endif
  input  logic [31:0] ir,
  input  logic        con,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout, RYin,
  output logic        MARin, MDRin, IRin, PCin, HIin, LOin, Zhighin, Zlowin, OutPort_write,
  output logic        PCout, MDRout, HIout, LOout, Zhighout, Zlowout, Cout, InPort_read,
  output logic        pc_increment, read, memoryRead, memoryWrite,
  output logic [4:0]  alu_control,
  output logic        halted,
  output logic [3:0]  step
);

  state_e     state_q, state_d;
  iclass_e    iclass;
  logic [3:0] last_step;
  logic [3:0] state_idx;
  logic [4:0] opcode;
  logic       stall;
  logic       unused_ir;
  ctrl_t      c;

  assign opcode    = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign state_idx = state_q;

`ifdef CU_SINGLE_STEP_EN
  assign stall = (state_q == S_FETCH0) && !step_req;
`else
  assign stall = 1'b0;
`endif

  cu_decode u_decode (
    .opcode    (opcode),
    .iclass    (iclass),
    .last_step (last_step)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH0: if (!stall) state_d = S_FETCH1;
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_FETCH3;
      S_FETCH3: begin
        if (iclass == CL_HALT)       state_d = S_HALT;
        else if (last_step == 4'd3)  state_d = S_FETCH0;
        else                         state_d = S_T4;
      end
      S_HALT:   state_d = S_HALT;
      default: begin
        if (state_idx >= last_step || state_q == S_T9) state_d = S_FETCH0;
        else                                           state_d = state_e'(state_idx + 4'd1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state_q <= S_FETCH0;
    else     state_q <= state_d;
  end

  // Strobe decode of (state, class); con only reaches PCin at branch T7.
  always_comb begin
    c = '0;
    case (state_q)
      S_FETCH0: begin c.pcout = 1'b1; c.marin = 1'b1; c.pc_increment = 1'b1; end
      S_FETCH1: c.memory_read = 1'b1;
      S_FETCH2: begin c.memory_read = 1'b1; c.read = 1'b1; c.mdrin = 1'b1; end
      S_FETCH3: begin c.mdrout = 1'b1; c.irin = 1'b1; end
      S_HALT:   c = '0;
      default: begin
        case (iclass)
          CL_ALU, CL_IMM: begin
            if (state_q == S_T4) begin c.grb = 1'b1; c.rout = 1'b1; c.ryin = 1'b1; end
            if (state_q == S_T5) begin
              c.zlowin = 1'b1; c.alu = opcode;
              if (iclass == CL_ALU) begin c.grc = 1'b1; c.rout = 1'b1; end
              else                  c.cout = 1'b1;
            end
            if (state_q == S_T6) begin c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          end
          CL_UNARY: begin
            if (state_q == S_T4) begin c.grb = 1'b1; c.rout = 1'b1; c.zlowin = 1'b1; c.alu = opcode; end
            if (state_q == S_T5) begin c.zlowout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          end
          CL_MULDIV: begin
            if (state_q == S_T4) begin c.gra = 1'b1; c.rout = 1'b1; c.ryin = 1'b1; end
            if (state_q == S_T5) begin
              c.grb = 1'b1; c.rout = 1'b1; c.zlowin = 1'b1; c.zhighin = 1'b1; c.alu = opcode;
            end
            if (state_q == S_T6) begin c.zlowout = 1'b1; c.loin = 1'b1; end
            if (state_q == S_T7) begin c.zhighout = 1'b1; c.hiin = 1'b1; end
          end
          CL_LD, CL_LDI, CL_ST: begin
            if (state_q == S_T4) begin c.grb = 1'b1; c.baout = 1'b1; c.rout = 1'b1; c.ryin = 1'b1; end
            if (state_q == S_T5) begin c.cout = 1'b1; c.zlowin = 1'b1; c.alu = ADD_OP; end
            if (state_q == S_T6) begin
              c.zlowout = 1'b1;
              if (iclass == CL_LDI) begin c.gra = 1'b1; c.rin = 1'b1; end
              else                  c.marin = 1'b1;
            end
            if (iclass == CL_LD) begin
              if (state_q == S_T7) c.memory_read = 1'b1;
              if (state_q == S_T8) begin c.memory_read = 1'b1; c.read = 1'b1; c.mdrin = 1'b1; end
              if (state_q == S_T9) begin c.mdrout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
            end
            if (iclass == CL_ST) begin
              if (state_q == S_T7) begin c.gra = 1'b1; c.rout = 1'b1; c.mdrin = 1'b1; end
              if (state_q == S_T8) c.memory_write = 1'b1;
            end
          end
          CL_BR: begin
            if (state_q == S_T4) begin c.gra = 1'b1; c.rout = 1'b1; end
            if (state_q == S_T5) begin c.pcout = 1'b1; c.ryin = 1'b1; end
            if (state_q == S_T6) begin c.cout = 1'b1; c.zlowin = 1'b1; c.alu = ADD_OP; end
            if (state_q == S_T7) begin c.zlowout = 1'b1; c.pcin = con; end
          end
          CL_JR:   if (state_q == S_T4) begin c.gra = 1'b1; c.rout = 1'b1; c.pcin = 1'b1; end
          CL_JAL: begin
            if (state_q == S_T4) begin c.pcout = 1'b1; c.grb = 1'b1; c.rin = 1'b1; end
            if (state_q == S_T5) begin c.gra = 1'b1; c.rout = 1'b1; c.pcin = 1'b1; end
          end
          CL_IN:   if (state_q == S_T4) begin c.inport_read = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          CL_OUT:  if (state_q == S_T4) begin c.gra = 1'b1; c.rout = 1'b1; c.outport_write = 1'b1; end
          CL_MFHI: if (state_q == S_T4) begin c.hiout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          CL_MFLO: if (state_q == S_T4) begin c.loout = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          default: c = '0;
        endcase
      end
    endcase
    if (clr || stall) c = '0;
  end

  assign Gra = c.gra;   assign Grb = c.grb;   assign Grc = c.grc;
  assign Rin = c.rin;   assign Rout = c.rout; assign BAout = c.baout; assign RYin = c.ryin;
  assign MARin = c.marin; assign MDRin = c.mdrin; assign IRin = c.irin; assign PCin = c.pcin;
  assign HIin = c.hiin; assign LOin = c.loin; assign Zhighin = c.zhighin; assign Zlowin = c.zlowin;
  assign OutPort_write = c.outport_write;
  assign PCout = c.pcout; assign MDRout = c.mdrout; assign HIout = c.hiout; assign LOout = c.loout;
  assign Zhighout = c.zhighout; assign Zlowout = c.zlowout; assign Cout = c.cout;
  assign InPort_read = c.inport_read;
  assign pc_increment = c.pc_increment; assign read = c.read;
  assign memoryRead = c.memory_read; assign memoryWrite = c.memory_write;
  assign alu_control = c.alu;

  assign halted = !clr && (state_q == S_HALT);
  assign step   = (clr || state_q == S_HALT) ? 4'd0 : state_idx;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module      : tb_control_unit
// Description : Scoreboard bench for control_unit; every cycle's full output
//               vector is predicted when an instruction is issued.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr, con;
  logic [31:0] ir;
`ifdef CU_SINGLE_STEP_EN
  logic        step_req;
`endif
  logic Gra, Grb, Grc, Rin, Rout, BAout, RYin;
  logic MARin, MDRin, IRin, PCin, HIin, LOin, Zhighin, Zlowin, OutPort_write;
  logic PCout, MDRout, HIout, LOout, Zhighout, Zlowout, Cout, InPort_read;
  logic pc_increment, read, memoryRead, memoryWrite;
  logic [4:0] alu_control;
  logic       halted;
  logic [3:0] step;

  control_unit #(.ADD_OP(5'b00011)) dut (
    .clk(clk), .clr(clr),
`ifdef CU_SINGLE_STEP_EN
    .step_req(step_req),
`endif
    .ir(ir), .con(con),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .RYin(RYin),
    .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .PCin(PCin), .HIin(HIin), .LOin(LOin),
    .Zhighin(Zhighin), .Zlowin(Zlowin), .OutPort_write(OutPort_write),
    .PCout(PCout), .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .Cout(Cout), .InPort_read(InPort_read),
    .pc_increment(pc_increment), .read(read), .memoryRead(memoryRead), .memoryWrite(memoryWrite),
    .alu_control(alu_control), .halted(halted), .step(step)
  );

  always #5 clk = ~clk;

  localparam logic [27:0] M_GRA = 28'd1 << 0,  M_GRB = 28'd1 << 1,  M_GRC = 28'd1 << 2;
  localparam logic [27:0] M_RIN = 28'd1 << 3,  M_ROUT = 28'd1 << 4, M_BAOUT = 28'd1 << 5;
  localparam logic [27:0] M_RYIN = 28'd1 << 6, M_MARIN = 28'd1 << 7, M_MDRIN = 28'd1 << 8;
  localparam logic [27:0] M_IRIN = 28'd1 << 9, M_PCIN = 28'd1 << 10, M_HIIN = 28'd1 << 11;
  localparam logic [27:0] M_LOIN = 28'd1 << 12, M_ZHIN = 28'd1 << 13, M_ZLIN = 28'd1 << 14;
  localparam logic [27:0] M_OUTW = 28'd1 << 15, M_PCOUT = 28'd1 << 16, M_MDROUT = 28'd1 << 17;
  localparam logic [27:0] M_HIOUT = 28'd1 << 18, M_LOOUT = 28'd1 << 19, M_ZHOUT = 28'd1 << 20;
  localparam logic [27:0] M_ZLOUT = 28'd1 << 21, M_COUT = 28'd1 << 22, M_INR = 28'd1 << 23;
  localparam logic [27:0] M_PCINC = 28'd1 << 24, M_READ = 28'd1 << 25, M_MRD = 28'd1 << 26;
  localparam logic [27:0] M_MWR = 28'd1 << 27;

  logic [37:0] obs;
  assign obs = {step, halted, alu_control,
                memoryWrite, memoryRead, read, pc_increment, InPort_read, Cout, Zlowout, Zhighout,
                LOout, HIout, MDRout, PCout, OutPort_write, Zlowin, Zhighin, LOin, HIin, PCin,
                IRin, MDRin, MARin, RYin, BAout, Rout, Rin, Grc, Grb, Gra};

  logic [37:0] exp_q[$];
  string       tag_q[$];
  string       cur_name;
  int          s_idx;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [37:0] got, input logic [37:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] vec(input int stp, input logic [27:0] m,
                                      input logic [4:0] alu, input logic h);
    return {4'(stp), h, alu, m};
  endfunction

  task automatic push(input string tag, input logic [37:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic px(input logic [27:0] m, input logic [4:0] alu);
    push($sformatf("%s_t%0d", cur_name, s_idx), vec(s_idx, m, alu, 1'b0));
    s_idx++;
  endtask

  task automatic push_instr(input string name, input logic [4:0] op, input logic c);
    cur_name = name;
    s_idx    = 0;
    px(M_PCOUT | M_MARIN | M_PCINC, 5'd0);
    px(M_MRD, 5'd0);
    px(M_MRD | M_READ | M_MDRIN, 5'd0);
    px(M_MDROUT | M_IRIN, 5'd0);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011: begin
        px(M_GRB | M_ROUT | M_RYIN, 5'd0);
        px(M_GRC | M_ROUT | M_ZLIN, op);
        px(M_ZLOUT | M_GRA | M_RIN, 5'd0);
      end
      5'b01100, 5'b01101, 5'b01110: begin
        px(M_GRB | M_ROUT | M_RYIN, 5'd0);
        px(M_COUT | M_ZLIN, op);
        px(M_ZLOUT | M_GRA | M_RIN, 5'd0);
      end
      5'b10001, 5'b10010: begin
        px(M_GRB | M_ROUT | M_ZLIN, op);
        px(M_ZLOUT | M_GRA | M_RIN, 5'd0);
      end
      5'b10000, 5'b01111: begin
        px(M_GRA | M_ROUT | M_RYIN, 5'd0);
        px(M_GRB | M_ROUT | M_ZLIN | M_ZHIN, op);
        px(M_ZLOUT | M_LOIN, 5'd0);
        px(M_ZHOUT | M_HIIN, 5'd0);
      end
      5'b00000, 5'b00001, 5'b00010: begin
        px(M_GRB | M_BAOUT | M_ROUT | M_RYIN, 5'd0);
        px(M_COUT | M_ZLIN, 5'b00011);
        if (op == 5'b00001) px(M_ZLOUT | M_GRA | M_RIN, 5'd0);
        else                px(M_ZLOUT | M_MARIN, 5'd0);
        if (op == 5'b00000) begin
          px(M_MRD, 5'd0);
          px(M_MRD | M_READ | M_MDRIN, 5'd0);
          px(M_MDROUT | M_GRA | M_RIN, 5'd0);
        end
        if (op == 5'b00010) begin
          px(M_GRA | M_ROUT | M_MDRIN, 5'd0);
          px(M_MWR, 5'd0);
        end
      end
      5'b10011: begin
        px(M_GRA | M_ROUT, 5'd0);
        px(M_PCOUT | M_RYIN, 5'd0);
        px(M_COUT | M_ZLIN, 5'b00011);
        px(M_ZLOUT | (c ? M_PCIN : 28'd0), 5'd0);
      end
      5'b10100: px(M_GRA | M_ROUT | M_PCIN, 5'd0);
      5'b10101: begin
        px(M_PCOUT | M_GRB | M_RIN, 5'd0);
        px(M_GRA | M_ROUT | M_PCIN, 5'd0);
      end
      5'b10110: px(M_INR | M_GRA | M_RIN, 5'd0);
      5'b10111: px(M_GRA | M_ROUT | M_OUTW, 5'd0);
      5'b11001: px(M_HIOUT | M_GRA | M_RIN, 5'd0);
      5'b11000: px(M_LOOUT | M_GRA | M_RIN, 5'd0);
      default: ;
    endcase
  endtask

  // Compare up to n queued cycles; each cycle sampled on the falling edge.
  task automatic drain(input int n);
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      @(negedge clk);
      check(tag_q.pop_front(), obs, exp_q.pop_front());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input string name, input logic [4:0] op, input logic c);
    ir  = {op, 27'($urandom)};
    con = c;
    push_instr(name, op, c);
    drain(exp_q.size());
  endtask

  initial begin
    clr = 1'b1;
    con = 1'b0;
    ir  = 32'h0;
`ifdef CU_SINGLE_STEP_EN
    step_req = 1'b1;
`endif
    @(posedge clk);
    #1;
    push("reset0", 38'd0);
    push("reset1", 38'd0);
    drain(2);
    clr = 1'b0;

    run("add",  5'b00011, 1'b0);
    run("sub",  5'b00100, 1'b0);
    run("shl",  5'b01011, 1'b0);
    run("addi", 5'b01100, 1'b0);
    run("ori",  5'b01110, 1'b0);
    run("neg",  5'b10001, 1'b0);
    run("not",  5'b10010, 1'b0);
    run("mul",  5'b10000, 1'b0);
    run("div",  5'b01111, 1'b0);
    run("ld",   5'b00000, 1'b0);
    run("ldi",  5'b00001, 1'b0);
    run("st",   5'b00010, 1'b0);
    run("br0",  5'b10011, 1'b0);
    run("br1",  5'b10011, 1'b1);
    run("jr",   5'b10100, 1'b0);
    run("jal",  5'b10101, 1'b0);
    run("in",   5'b10110, 1'b0);
    run("out",  5'b10111, 1'b0);
    run("mfhi", 5'b11001, 1'b0);
    run("mflo", 5'b11000, 1'b0);
    run("nop",  5'b11010, 1'b0);
    run("unk",  5'b11111, 1'b0);

    // Halt holds for 20 cycles, then a clr pulse restarts fetch.
    ir = {5'b11011, 27'($urandom)};
    push_instr("halt", 5'b11011, 1'b0);
    for (int i = 0; i < 20; i++) push($sformatf("halted%0d", i), vec(0, 28'd0, 5'd0, 1'b1));
    drain(exp_q.size());
    clr = 1'b1;
    push("clr_halt", 38'd0);
    drain(1);
    clr = 1'b0;
    run("post_halt_add", 5'b00011, 1'b0);

    // Reset landing on st T7 must suppress the later memory write.
    ir = {5'b00010, 27'($urandom)};
    push_instr("st_abort", 5'b00010, 1'b0);
    drain(7);
    exp_q.delete();
    tag_q.delete();
    clr = 1'b1;
    push("clr_st_t7", 38'd0);
    drain(1);
    clr = 1'b0;
    run("post_clr_nop", 5'b11010, 1'b0);
    run("post_clr_ld",  5'b00000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_unit.md
# control_unit

Hardwired Moore control sequencer for the Mini SRC datapath. It decodes the instruction held in IR and steps through fetch and execute micro-steps. On each step it drives the datapath's register-transfer strobes (Gra/Grb/Grc, Rin/Rout, BAout, bus-out selects, latch enables, memory strobes, and the 5-bit ALU op). It sits directly upstream of the datapath and consumes only `ir` and the CON FF result `con` coming back from it.

## Interface
Parameters:
- `ADD_OP`, 5'b00011, ALU op used for address, immediate and branch-target arithmetic.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `ir`  in  32  current IR contents; opcode is `ir[31:27]`.
- `con`  in  1  CON FF result, valid the cycle after the branch condition register is on the bus.
- `Gra, Grb, Grc, Rin, Rout, BAout, RYin`  out  1 each  register select/strobe controls.
- `MARin, MDRin, IRin, PCin, HIin, LOin, Zhighin, Zlowin, OutPort_write`  out  1 each  latch enables.
- `PCout, MDRout, HIout, LOout, Zhighout, Zlowout, Cout, InPort_read`  out  1 each  bus drivers; at most one driver is active per step.
- `pc_increment, read, memoryRead, memoryWrite`  out  1 each  PC and memory controls.
- `alu_control`  out  5  ALU op; equals the opcode for ALU-class instructions, `ADD_OP` elsewhere, and 0 when idle.
- `halted`  out  1  high while in HALT.
- `step`  out  4  current micro-step index T0..T9, for debug.

## Operation
- States are FETCH0..FETCH3, EXEC T4..T9, and HALT. Outputs are a pure decode of (state, opcode). No output depends combinationally on `con`, except PCin at branch T7.
- Fetch:
  - FETCH0: PCout, MARin, pc_increment.
  - FETCH1: memoryRead.
  - FETCH2: memoryRead, read, MDRin.
  - FETCH3: MDRout, IRin.
- Reg-reg ALU ops (add, sub, and, or, ror, rol, shr, shra, shl):
  - T4: Grb, Rout, RYin.
  - T5: Grc, Rout, Zlowin.
  - T6: Zlowout, Gra, Rin. Then FETCH0.
- addi, andi, ori: as reg-reg, but T5 uses Cout in place of Grc/Rout.
- neg, not: T4 Grb, Rout, Zlowin; T5 Zlowout, Gra, Rin.
- mul, div:
  - T4: Gra, Rout, RYin.
  - T5: Grb, Rout, Zlowin, Zhighin.
  - T6: Zlowout, LOin.
  - T7: Zhighout, HIin.
- ld, ldi:
  - T4: Grb, BAout, Rout, RYin.
  - T5: Cout, Zlowin.
  - ldi then does T6 Zlowout, Gra, Rin.
  - ld then does T6 Zlowout, MARin; T7 memoryRead; T8 memoryRead, read, MDRin; T9 MDRout, Gra, Rin.
- st: T4/T5 as ld; T6 Zlowout, MARin; T7 Gra, Rout, MDRin; T8 memoryWrite.
- br:
  - T4: Gra, Rout (CON FF loads).
  - T5: PCout, RYin.
  - T6: Cout, Zlowin.
  - T7: Zlowout, and PCin only if `con`=1.
- jr: T4 Gra, Rout, PCin.
- jal: T4 PCout, Grb, Rin (link register = rb field); T5 Gra, Rout, PCin.
- in: T4 InPort_read, Gra, Rin. out: T4 Gra, Rout, OutPort_write.
- mfhi / mflo: T4 HIout or LOout, Gra, Rin.
- nop returns to FETCH0 after FETCH3.
- halt enters HALT. HALT drives all outputs 0 and holds until `clr`.
- Unknown opcode behaves as nop.

## Timing
- While `clr`=1: next state is FETCH0, and every output is 0 that cycle. This includes `halted`=0 and `step`=0.
- Reset mid-instruction abandons the sequence with no partial write. Fetch restarts at FETCH0 on the first edge after `clr` deasserts.
- Memory read latency is one cycle, so memoryRead is held two steps and MDRin is raised in the second.
- Instruction latency in cycles, including the 4 fetch cycles:
  - reg-reg/immediate: 7
  - neg/not: 6
  - mul/div: 8
  - ldi: 7
  - ld: 10
  - st: 9
  - br: 8
  - jr, in, out, mfhi, mflo: 5
  - jal: 6
  - nop: 4
- The last execute step always transitions to FETCH0 on the next edge.

## Configuration
- `CU_SINGLE_STEP_EN` defined:
  - Adds input port `step_req` (1 bit).
  - FETCH0 outputs stay 0 and the state stalls in FETCH0 until `step_req`=1 is sampled. That cycle performs the normal FETCH0 actions and advances.
  - An instruction already in progress always completes.
- Undefined: no `step_req` port; FETCH0 never stalls.

## Structure
- Package `cu_pkg` holds:
  - the 5-bit opcode constants: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, ror=00111, rol=01000, shr=01001, shra=01010, shl=01011, addi=01100, andi=01101, ori=01110, div=01111, mul=10000, neg=10001, not=10010, br=10011, jr=10100, jal=10101, in=10110, out=10111, mflo=11000, mfhi=11001, nop=11010, halt=11011;
  - the state enum.
- One sub-module, `cu_decode`, is combinational: it maps opcode to an instruction class and last-step index.

## Test plan
- Reset then `ir`=add r1,r2,r3 → FETCH0 raises PCout, MARin, pc_increment; T5 raises alu_control=00011 and Zlowin; Gra/Rin at cycle 7; back to FETCH0 at cycle 8.
- ld r1,0x54(r0) → BAout=1 at T4; MARin at T6; MDRin with read at T8; Rin at T9; 10 cycles total.
- br with `con`=0, then with `con`=1 → PCin stays 0 and goes 1 at T7 respectively.
- mul → LOin at T6, HIin at T7; both Zlowin and Zhighin at T5.
- halt → `halted`=1 and all strobes 0 for 20 cycles. Then `clr` pulse → FETCH0 actions one cycle after release.
- `clr` asserted during st T7 → memoryWrite never asserts; `step`=0.
